// File: rtl/srl8_fifo_if.sv
// Stream bundle for srl8_fifo: write side (S_*), read side (M_*) and occupancy.
// The FIFO attaches through 'slave'; the producer/consumer side uses 'master'.
interface srl8_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LVL_WIDTH  = 5
);
  logic [DATA_WIDTH-1:0] S_DATA;
  logic                  S_VALID;
  logic                  S_READY;
  logic [DATA_WIDTH-1:0] M_DATA;
  logic                  M_VALID;
  logic                  M_READY;
  logic [LVL_WIDTH-1:0]  LEVEL;

  modport slave (
    input  S_DATA, S_VALID, M_READY,
    output S_READY, M_DATA, M_VALID, LEVEL
  );

  modport master (
    output S_DATA, S_VALID, M_READY,
    input  S_READY, M_DATA, M_VALID, LEVEL
  );
endinterface

// File: rtl/srl8_fifo.sv
// Shallow FIFO on a serial-in shift register: words enter at tap 0, and the
// oldest word is read from tap cnt-1 into a registered valid/ready output stage.
module srl8_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int LVL_WIDTH  = 5
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         FLUSH,
  srl8_fifo_if.slave   bus
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] sr_q [DEPTH];
  logic [DATA_WIDTH-1:0] sr_d [DEPTH];

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

  logic                  clr;
  logic                  s_ready;
  logic                  push;
  logic                  pop;
  logic                  load;
  logic [IDX_WIDTH-1:0]  rd_idx;

  assign clr     = RST | FLUSH;
  // Ready is a pure function of registered occupancy, never of M_READY.
  assign s_ready = (cnt_q != CNT_FULL);
  assign push    = bus.S_VALID & s_ready;
  assign pop     = m_valid_q & bus.M_READY;
  assign load    = (cnt_q != '0) & (~m_valid_q | pop);
  assign rd_idx  = (cnt_q == '0) ? '0 : IDX_WIDTH'(cnt_q - 1'b1);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sr
      if (gi == 0) begin : g_head
        assign sr_d[gi] = push ? bus.S_DATA : sr_q[gi];
      end else begin : g_tail
        assign sr_d[gi] = push ? sr_q[gi-1] : sr_q[gi];
      end
    end
  endgenerate

  // Storage is intentionally left unreset; cnt alone defines which taps are live.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      sr_q[i] <= sr_d[i];
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    case ({push, load})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // The output tap is read from pre-edge contents even when a push shifts.
    if (load) begin
      m_data_d  = sr_q[rd_idx];
      m_valid_d = 1'b1;
    end else if (pop) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign bus.S_READY = s_ready;
  assign bus.M_DATA  = m_data_q;
  assign bus.M_VALID = m_valid_q;
  assign bus.LEVEL   = LVL_WIDTH'(cnt_q) + LVL_WIDTH'(m_valid_q);

endmodule

// File: tb/tb_srl8_fifo.sv
// Self-checking bench for srl8_fifo: vector table, occupancy model and data scoreboard.
module tb_srl8_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int LW    = 5;

  logic CLK = 1'b0;
  logic RST;
  logic FLUSH;

  srl8_fifo_if #(.DATA_WIDTH(DW), .LVL_WIDTH(LW)) bus ();

  srl8_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LVL_WIDTH(LW)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .FLUSH (FLUSH),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit             sv;
    logic [DW-1:0]  sd;
    bit             mr;
    int             lvl;
    bit             mv;
    logic [DW-1:0]  md;
    bit             rdy;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] sb[$];
  int            m_cnt;
  bit            m_vld;
  bit            last_push;
  int            words_out;
  int            tests;
  int            fails;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("s_ready", 32'(bus.S_READY), 32'(m_cnt != DEPTH));
    chk("m_valid", 32'(bus.M_VALID), 32'(m_vld));
    chk("level",   32'(bus.LEVEL),   32'(m_cnt + int'(m_vld)));
    if (m_vld && sb.size() > 0)
      chk("m_data_head", 32'(bus.M_DATA), 32'(sb[0]));
  endtask

  // One clock: check current outputs, drive inputs, advance model, step to next negedge.
  task automatic cycle(input bit sv, input logic [DW-1:0] sd, input bit mr, input bit fl);
    int  n_cnt;
    bit  n_vld;
    bit  push, pop, load;
    check_state();
    bus.S_VALID = sv;
    bus.S_DATA  = sd;
    bus.M_READY = mr;
    FLUSH       = fl;
    last_push   = 1'b0;
    if (fl) begin
      n_cnt = 0;
      n_vld = 1'b0;
      sb.delete();
      $display("[TB] flush");
    end else begin
      push  = sv && (m_cnt != DEPTH);
      pop   = m_vld && mr;
      load  = (m_cnt != 0) && (!m_vld || pop);
      n_cnt = m_cnt + int'(push) - int'(load);
      n_vld = load ? 1'b1 : (pop ? 1'b0 : m_vld);
      if (pop && sb.size() > 0) begin
        chk("pop_data", 32'(bus.M_DATA), 32'(sb[0]));
        $display("[TB] out %02h", bus.M_DATA);
        void'(sb.pop_front());
        words_out++;
      end
      if (push) begin
        sb.push_back(sd);
        last_push = 1'b1;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    m_cnt = n_cnt;
    m_vld = n_vld;
    FLUSH = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   cyc;
    int   pushed;

    tests = 0; fails = 0; words_out = 0;
    bus.S_VALID = 1'b0; bus.S_DATA = '0; bus.M_READY = 1'b0;
    FLUSH = 1'b0;
    RST   = 1'b1;

    // Vectors: expected state after each edge.
    v = '{1, 8'hA5, 0, 1, 0, 8'h00, 1}; tbl.push_back(v);
    v = '{0, 8'h00, 0, 1, 1, 8'hA5, 1}; tbl.push_back(v);
    v = '{0, 8'h00, 1, 0, 0, 8'h00, 1}; tbl.push_back(v);
    v = '{1, 8'h01, 0, 1, 0, 8'h00, 1}; tbl.push_back(v);
    for (int k = 2; k <= 9; k++) begin
      v = '{1, 8'(k), 0, k, 1, 8'h01, (k != 9)};
      tbl.push_back(v);
    end
    v = '{1, 8'h0A, 0, 9, 1, 8'h01, 0}; tbl.push_back(v);
    for (int i = 0; i <= 8; i++) begin
      v = '{0, 8'h00, 1, 8 - i, (i != 8), 8'(i + 2), 1};
      tbl.push_back(v);
    end

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    m_cnt = 0; m_vld = 1'b0; sb.delete();
    chk("rst_s_ready", 32'(bus.S_READY), 32'd1);
    chk("rst_m_valid", 32'(bus.M_VALID), 32'd0);
    chk("rst_m_data",  32'(bus.M_DATA),  32'h00);
    chk("rst_level",   32'(bus.LEVEL),   32'd0);

    foreach (tbl[i]) begin
      cycle(tbl[i].sv, tbl[i].sd, tbl[i].mr, 1'b0);
      $display("[TB] vec %0d: level=%0d m_valid=%0d m_data=%02h", i, bus.LEVEL, bus.M_VALID, bus.M_DATA);
      chk("vec_level",   32'(bus.LEVEL),   32'(tbl[i].lvl));
      chk("vec_m_valid", 32'(bus.M_VALID), 32'(tbl[i].mv));
      chk("vec_s_ready", 32'(bus.S_READY), 32'(tbl[i].rdy));
      if (tbl[i].mv) chk("vec_m_data", 32'(bus.M_DATA), 32'(tbl[i].md));
    end

    // Steady-state streaming: level settles at 2 with no bubbles.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
      if (i >= 1) begin
        chk("stream_level",   32'(bus.LEVEL),   32'd2);
        chk("stream_m_valid", 32'(bus.M_VALID), 32'd1);
      end
    end
    cyc = 0;
    while ((m_cnt != 0 || m_vld) && cyc < 50) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cyc++;
    end
    chk("stream_drained", 32'(bus.LEVEL), 32'd0);

    // Random backpressure, 1000 accepted words.
    words_out = 0; pushed = 0; cyc = 0;
    while (pushed < 1000 && cyc < 20000) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      if (last_push) pushed++;
      cyc++;
      if (bus.LEVEL > LW'(DEPTH + 1)) chk("rand_level_max", 32'(bus.LEVEL), 32'(DEPTH + 1));
    end
    chk("rand_pushed", 32'(pushed), 32'd1000);
    cyc = 0;
    while ((m_cnt != 0 || m_vld) && cyc < 200) begin
      cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
      cyc++;
    end
    chk("rand_drain_done", 32'(m_cnt + int'(m_vld)), 32'd0);
    chk("rand_words_out", 32'(words_out), 32'd1000);

    // Flush mid-stream with concurrent push and pop.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    chk("pre_flush_level", 32'(bus.LEVEL), 32'd5);
    cycle(1'b1, 8'h77, 1'b1, 1'b1);
    chk("flush_level",   32'(bus.LEVEL),   32'd0);
    chk("flush_m_valid", 32'(bus.M_VALID), 32'd0);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_flush_m_valid", 32'(bus.M_VALID), 32'd1);
    chk("post_flush_m_data",  32'(bus.M_DATA),  32'h3C);
    chk("post_flush_level",   32'(bus.LEVEL),   32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_state();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/srl8_fifo.md
Name: srl8_fifo

Overview:
- Shallow synchronous FIFO built on addressable shift-register storage. Writes shift in at tap 0; reads come from a variable tap selected by the current occupancy. This is the reader/pointer side that makes a serial-in, addressable-tap shift register usable as a queue.
- A registered output stage gives a valid/ready stream on both sides.
- Sits between line-buffer and scaler-kernel stages in the video pipeline for small rate decoupling.

Parameters:
- DATA_WIDTH, 8, width of each word.
- DEPTH, 8, number of shift-register storage words; legal range 2..16. Total capacity is DEPTH+1 (storage plus output register).
- LVL_WIDTH, 5, width of LEVEL; must be at least clog2(DEPTH+2).

Ports:
- CLK  input  1  clock; rising edge.
- RST  input  1  synchronous reset, active-high.
- FLUSH  input  1  synchronous clear of all contents; same effect as RST.
- S_DATA  input  DATA_WIDTH  write data.
- S_VALID  input  1  write request.
- S_READY  output  1  FIFO can accept a word this cycle.
- M_DATA  output  DATA_WIDTH  read data, registered.
- M_VALID  output  1  M_DATA holds a valid word.
- M_READY  input  1  consumer takes the word.
- LEVEL  output  LVL_WIDTH  total words held (storage + output register).

Behaviour:
- State: storage array sr[0..DEPTH-1] (not reset); occupancy counter cnt (0..DEPTH); output register M_DATA/M_VALID.
- Reset (RST or FLUSH high at the edge): cnt=0, M_VALID=0, M_DATA=0. Storage contents are don't-care. Reset has priority over all traffic in the same cycle. Reset mid-stream discards all words.
- Outputs immediately after reset: S_READY=1, M_VALID=0, M_DATA=0, LEVEL=0.
- S_READY = (cnt != DEPTH). It depends only on registered state; no combinational path from M_READY.
- push = S_VALID & S_READY. On push: sr[0]<=S_DATA and sr[i]<=sr[i-1] for i=1..DEPTH-1, all in one edge.
- pop = M_VALID & M_READY.
- load = (cnt != 0) & (!M_VALID | pop). On load, M_DATA <= sr[cnt-1] (the oldest word), read from pre-edge contents. This holds even when push shifts in the same edge.
- M_VALID next: 1 if load; else 0 if pop; else unchanged.
- cnt next = cnt + push - load, with no wrap. Push when cnt=DEPTH cannot occur (S_READY=0). Load when cnt=0 cannot occur.
- Simultaneous push+load at cnt=DEPTH is impossible; at any other cnt, cnt is unchanged.
- LEVEL = cnt + M_VALID, combinational from registers.
- Latency:
  - A word accepted at edge N is in storage after edge N.
  - It is loaded into the output register at edge N+1 if the output is free; M_VALID rises after edge N+1.
  - There is no storage bypass.
- M_DATA and M_VALID hold stable while M_VALID=1 and M_READY=0.
- Ordering is strictly first-in first-out. No word is lost or duplicated under any S_VALID/M_READY pattern.
- S_VALID while S_READY=0 is ignored. M_READY while M_VALID=0 is ignored.
- Full: cnt=DEPTH, and LEVEL=DEPTH+1 when M_VALID=1. Empty: LEVEL=0.

Test Plan:
- Reset/idle (DEPTH=8, DATA_WIDTH=8): hold RST 2 cycles -> S_READY=1, M_VALID=0, M_DATA=0x00, LEVEL=0.
- Single word: push 0xA5 at edge N with M_READY=0 -> after N, LEVEL=1 and M_VALID=0. After N+1, M_VALID=1, M_DATA=0xA5, LEVEL=1. Pulse M_READY -> M_VALID=0, LEVEL=0.
- Fill to full: push 0x01..0x09 with M_READY=0 -> S_READY=0 after the 9th accept, LEVEL=9, cnt=8. A 10th S_VALID (0x0A) is not accepted. Drain with M_READY=1 -> outputs 0x01..0x09 in order, then M_VALID=0.
- Simultaneous push/pop at steady state: with S_VALID=1 and M_READY=1 continuously on an incrementing data stream -> one word out per cycle after a 2-cycle fill, LEVEL stays constant, no gaps or reordering.
- Random backpressure: 1000 words with random S_VALID/M_READY (50%) -> scoreboard matches exactly. LEVEL never exceeds 9. S_READY=0 exactly when cnt=8.
- Flush mid-stream: with LEVEL=5, assert FLUSH together with S_VALID=1 and M_READY=1 -> next cycle LEVEL=0, M_VALID=0, and the concurrent word is discarded. A subsequent push of 0x3C is the next word read.
